// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus for instr_encoder.
// The master drives requests and observes the write port; the slave is the encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I fields plus a signed immediate into instruction words, range-checks the
// immediate and streams accepted words to instruction memory at an incrementing address.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  instr_encoder_if.slave       bus,
  output logic                 err,
  output logic [7:0]           err_cnt,
  output logic                 full
);

  localparam logic [6:0] OpR = 7'b0110011;
  localparam logic [6:0] OpI = 7'b0010011;
  localparam logic [6:0] OpL = 7'b0000011;
  localparam logic [6:0] OpS = 7'b0100011;
  localparam logic [6:0] OpB = 7'b1100011;
  localparam logic [6:0] OpU = 7'b0110111;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              wr_en_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;
  logic              full_q;

  logic [31:0] enc;
  logic        legal;
  logic        fits12;
  logic        fits13;
  logic        accept;
  logic        do_write;
  logic        do_err;

  // A value fits in N signed bits when every bit from N-1 upward equals the sign.
  assign fits12 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign fits13 = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (bus.fmt)
      3'd0: begin
        enc   = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OpR};
        legal = 1'b1;
      end
      3'd1: begin
        enc   = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OpI};
        legal = fits12;
      end
      3'd2: begin
        enc   = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OpL};
        legal = fits12;
      end
      3'd3: begin
        enc   = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], OpS};
        legal = fits12;
      end
      3'd4: begin
        enc   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:1],
                 bus.imm[11], OpB};
        legal = fits13 & ~bus.imm[0];
      end
      3'd5: begin
        enc   = {bus.imm[31:12], bus.rd, OpU};
        legal = (bus.imm[11:0] == 12'd0);
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign bus.in_ready = ~full_q & ~clear;
  assign accept       = bus.in_valid & bus.in_ready;
  assign do_write     = accept & legal;
  assign do_err       = accept & ~legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      full_q    <= 1'b0;
    end else begin
      wr_en_q <= do_write;
      err_q   <= do_err;
      if (clear) begin
        cnt_q     <= '0;
        wr_addr_q <= '0;
        err_cnt_q <= '0;
        full_q    <= 1'b0;
      end else begin
        if (do_write) begin
          wr_addr_q <= cnt_q;
          wr_data_q <= enc;
          // The counter parks on the last address instead of wrapping.
          if (cnt_q == LastAddr) begin
            full_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        if (do_err && (err_cnt_q != 8'hFF)) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
  assign full        = full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases plus randomized traffic checked every
// cycle against an arithmetic model of the encoder, counter, error count and full flag.
module tb_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       err;
  logic [7:0] err_cnt;
  logic       full;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .bus    (bus),
    .err    (err),
    .err_cnt(err_cnt),
    .full   (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int bnd [14] = '{-4097, -4096, -4094, -2049, -2048, -1, 0, 1, 2047, 2048, 4094, 4095, 4096,
                   -3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit model_legal(input logic [2:0] f, input logic [31:0] im);
    int s;
    s = $signed(im);
    case (f)
      3'd0:               return 1'b1;
      3'd1, 3'd2, 3'd3:   return (s >= -2048) && (s <= 2047);
      3'd4:               return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      3'd5:               return (s % 4096) == 0;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_enc(input logic [2:0] f, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] d,
                                            input logic [4:0] s1, input logic [4:0] s2,
                                            input logic [31:0] im);
    int unsigned u, regs;
    u    = im;
    regs = (32'(s1) << 15) | (32'(f3) << 12);
    case (f)
      3'd0: return (32'(f7) << 25) | (32'(s2) << 20) | regs | (32'(d) << 7) | 32'h33;
      3'd1: return ((u & 32'hFFF) << 20) | regs | (32'(d) << 7) | 32'h13;
      3'd2: return ((u & 32'hFFF) << 20) | regs | (32'(d) << 7) | 32'h03;
      3'd3: return (((u >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | regs |
                   ((u & 32'h1F) << 7) | 32'h23;
      3'd4: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(s2) << 20) |
                   regs | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      3'd5: return (u & 32'hFFFFF000) | (32'(d) << 7) | 32'h37;
      default: return 32'h0;
    endcase
  endfunction

  // Immediate recovered from an instruction word by sign extension of its fields.
  function automatic logic [31:0] signext(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'd1, 3'd2: return {{20{w[31]}}, w[31:20]};
      3'd3:       return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd4:       return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd5:       return {w[31:12], 12'h000};
      default:    return 32'h0;
    endcase
  endfunction

  int          m_addr;
  logic        m_full;
  logic [7:0]  m_errcnt;
  logic        m_wr_en;
  logic        m_err;
  logic [7:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic [31:0] m_imm;
  logic [2:0]  m_fmt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr <= 0; m_full <= 1'b0; m_errcnt <= 8'd0; m_wr_en <= 1'b0; m_err <= 1'b0;
      m_wr_addr <= 8'd0; m_wr_data <= 32'd0; m_imm <= 32'd0; m_fmt <= 3'd0;
    end else begin
      m_wr_en <= 1'b0;
      m_err   <= 1'b0;
      if (clear) begin
        m_addr <= 0; m_full <= 1'b0; m_errcnt <= 8'd0; m_wr_addr <= 8'd0;
      end else if (bus.in_valid && !m_full) begin
        if (model_legal(bus.fmt, bus.imm)) begin
          m_wr_en   <= 1'b1;
          m_wr_addr <= 8'(m_addr);
          m_wr_data <= model_enc(bus.fmt, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2,
                                 bus.imm);
          m_imm     <= bus.imm;
          m_fmt     <= bus.fmt;
          if (m_addr + 1 == DEPTH) m_full <= 1'b1;
          else m_addr <= m_addr + 1;
        end else begin
          m_err <= 1'b1;
          if (m_errcnt != 8'd255) m_errcnt <= m_errcnt + 8'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!m_full && !clear));
      chk("wr_en", 32'(bus.wr_en), 32'(m_wr_en));
      chk("err", 32'(err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
      chk("full", 32'(full), 32'(m_full));
      if (m_wr_en) begin
        chk("wr_addr", 32'(bus.wr_addr), 32'(m_wr_addr));
        chk("wr_data", bus.wr_data, m_wr_data);
        if (m_fmt != 3'd0) chk("signext", signext(m_fmt, bus.wr_data), m_imm);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input logic [2:0] f, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] im);
    bus.fmt = f; bus.funct3 = f3; bus.funct7 = f7;
    bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im;
  endtask

  // One request; returns at the negedge where its result is visible.
  task automatic req(input logic [2:0] f, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [31:0] im);
    @(posedge clk); #1;
    set_req(f, f3, f7, d, s1, s2, im);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic expect_write(input string name, input logic [7:0] a, input logic [31:0] d);
    chk({name, " wr_en"}, 32'(bus.wr_en), 32'd1);
    chk({name, " addr"}, 32'(bus.wr_addr), 32'(a));
    chk({name, " data"}, bus.wr_data, d);
  endtask

  task automatic expect_err(input string name, input logic [7:0] cnt);
    chk({name, " err"}, 32'(err), 32'd1);
    chk({name, " no wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({name, " err_cnt"}, 32'(err_cnt), 32'(cnt));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; bus.in_valid = 1'b0;
    set_req(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset wr_en", 32'(bus.wr_en), 32'd0);
    chk("reset wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("reset wr_data", bus.wr_data, 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    chk("reset full", 32'(full), 32'd0);
    rst_n = 1'b1;

    req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd1);
    expect_write("I imm=-1", 8'd0, 32'hFFF00093);
    req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047);
    expect_write("I imm=2047", 8'd1, 32'h7FF00093);
    req(3'd2, 3'd2, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    expect_write("L imm=0", 8'd2, 32'h00002003);
    req(3'd3, 3'd2, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd2048);
    expect_write("S imm=-2048", 8'd3, 32'h80002023);
    chk("S signext", signext(3'd3, bus.wr_data), -32'sd2048);
    chk("full after 4", 32'(full), 32'd1);

    pulse_clear();
    req(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
    expect_write("B imm=-4", 8'd0, 32'hFE208EE3);
    req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    expect_err("I 2048", 8'd1);
    req(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    expect_err("B odd", 8'd2);
    req(3'd5, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1001);
    expect_err("U low bits", 8'd3);
    req(3'd7, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    expect_err("fmt 7", 8'd4);
    chk("addr held after errors", 32'(bus.wr_addr), 32'd0);
    req(3'd5, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    expect_write("U", 8'd1, 32'h123452B7);
    req(3'd0, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0);
    expect_write("R", 8'd2, 32'h403100B3);

    // Five back-to-back requests into an empty block.
    pulse_clear();
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(3'd1, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'(i));
      @(posedge clk); #1;
      if (i < 4) begin
        chk("b2b wr_en", 32'(bus.wr_en), 32'd1);
        chk("b2b addr", 32'(bus.wr_addr), 32'(i));
      end else begin
        chk("fifth no write", 32'(bus.wr_en), 32'd0);
        chk("fifth full", 32'(full), 32'd1);
        chk("fifth in_ready", 32'(bus.in_ready), 32'd0);
        chk("addr holds last", 32'(bus.wr_addr), 32'(DEPTH - 1));
      end
    end
    bus.in_valid = 1'b0;
    pulse_clear();
    chk("full cleared", 32'(full), 32'd0);
    req(3'd1, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd5);
    expect_write("after clear", 8'd0, 32'h00500193);

    // Reset the cycle after an accept.
    @(posedge clk); #1;
    set_req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset wr_en", 32'(bus.wr_en), 32'd0);
    chk("midreset wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("midreset wr_data", bus.wr_data, 32'd0);
    chk("midreset full", 32'(full), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    expect_write("post reset", 8'd0, 32'h00700093);

    // Error counter saturation.
    pulse_clear();
    @(posedge clk); #1;
    set_req(3'd6, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.in_valid = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("err_cnt saturates", 32'(err_cnt), 32'd255);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      bus.in_valid = ($urandom_range(0, 9) < 7);
      clear        = ($urandom_range(0, 15) == 0);
      bus.fmt      = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                                 : 3'($urandom_range(0, 5));
      bus.funct3   = 3'($urandom);
      bus.funct7   = 7'($urandom);
      bus.rd       = 5'($urandom);
      bus.rs1      = 5'($urandom);
      bus.rs2      = 5'($urandom);
      case ($urandom_range(0, 4))
        0:       bus.imm = 32'(bnd[$urandom_range(0, 13)]);
        1:       bus.imm = $urandom;
        2:       bus.imm = $urandom & 32'hFFFFF000;
        3:       bus.imm = 32'($signed($urandom_range(0, 9000)) - 4500);
        default: bus.imm = 32'($signed($urandom_range(0, 4200)) - 2100) & 32'hFFFFFFFE;
      endcase
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs operation fields and a signed 32-bit immediate into RV32I instruction words (R/I/L/S/B/U formats).
- Range-checks each immediate and streams valid words into instruction memory through a write port with an auto-incrementing address.
- Used by the program loader and by benches to build test programs; output words must decode back through signext to the original immediate.

Parameters:
- ADDR_W, 8, width of the word address into instruction memory.
- DEPTH, 256, number of words writable before the full flag sets; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; zeroes the address, full flag and error count.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept; combinational: !full && !clear.
- fmt  in  3  format: 0=R(0110011), 1=I(0010011), 2=L(0000011), 3=S(0100011), 4=B(1100011), 5=U(0110111); values 6 and 7 are illegal.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; used only for R.
- rd, rs1, rs2  in  5 each  register fields.
- imm  in  32  signed immediate (byte offset for B).
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_W  word address of the current write.
- wr_data  out  32  encoded instruction.
- err  out  1  one-cycle pulse for a rejected request.
- err_cnt  out  8  count of rejected requests; saturates at 255.
- full  out  1  DEPTH words have been written.

Behaviour:
- Reset (rst_n low, asynchronous): wr_en=0, wr_addr=0, wr_data=0, err=0, err_cnt=0, full=0.
- Handshake: a request is accepted on a rising edge where in_valid && in_ready. Inputs are sampled only at that edge; there is no backpressure from memory.
- Latency: one cycle. The edge after acceptance registers wr_en=1, wr_data and wr_addr (the current address).
- The address counter increments after each write.
- When the counter reaches DEPTH, full=1 and wr_addr holds at DEPTH-1. Writes stop until clear or reset; the counter does not wrap.
- Encoding, standard RV32I field placement:
  - R: funct7|rs2|rs1|funct3|rd|op.
  - I and L: imm[11:0]|rs1|funct3|rd|op.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - Fields unused by a format are ignored.
- Range checks, evaluated on the full signed 32-bit imm:
  - I/L/S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - U: imm[11:0]=0.
  - R: no check.
- An illegal fmt or a failed check rejects the request: no write, err=1 for the next cycle, err_cnt+1. The address does not advance.
- Up to one write and one err pulse per cycle; they are mutually exclusive. Back-to-back accepts produce consecutive writes.
- clear asserted: in_ready=0 that cycle, so no accept. Next edge: address=0, full=0, err_cnt=0. A write already registered from the previous cycle still completes at its registered address.
- The last accept that fills the block (write to DEPTH-1) sets full on the same edge as that write. in_ready drops in the following cycle.
- Reset mid-stream discards any pending write.

Test Plan:
- I-type: fmt=1, funct3=0, rd=1, rs1=0, imm=-1 -> next cycle wr_en=1, wr_addr=0, wr_data=0xFFF00093. Then imm=2047 -> 0x7FF00093 at addr 1.
- L and S: fmt=2, funct3=2, all regs 0, imm=0 -> 0x00002003. Then fmt=3, funct3=2, imm=-2048 -> 0x80002023 at the next address. Feeding wr_data back through signext returns imm.
- Range errors: fmt=1 imm=2048; fmt=4 imm=3; fmt=5 imm=0x1001; fmt=7 -> four err pulses, err_cnt=4, no wr_en, wr_addr unchanged.
- B/U/R: fmt=4, funct3=0, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3. fmt=5, rd=5, imm=0x12345000 -> 0x123452B7. fmt=0, funct7=0x20, rs2=3, rs1=2, rd=1 -> 0x403100B3.
- Full (DEPTH=4): five back-to-back valid requests -> writes to addresses 0..3, full=1, in_ready=0, fifth not accepted. Pulse clear -> full=0, next write to address 0.
- Reset mid-stream: rst_n low the cycle after an accept -> no write, all outputs 0 immediately. After release, the first write goes to address 0.
